// File: rtl/fptd_iteration_controller_if.sv
// Handshake and status bundle between a frame requester and fptd_iteration_controller.
// The controller sits on the slave modport; the requester/array side uses master.
interface fptd_iteration_controller_if #(
    parameter int FL       = 40,
    parameter int MAX_ITER = 32
);
    localparam int CNT_W = $clog2(MAX_ITER + 1);

    logic             start;
    logic             stop;
    logic [CNT_W-1:0] iter_num;
    logic [FL-1:0]    err_vec;
    logic             nClear;
    logic             Enable_Odd;
    logic             Enable_Even;
    logic             Enable_Term;
    logic             Enable_Error_Counter;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] iter_cnt;
    logic [15:0]      err_iters;

    modport master (
        output start, stop, iter_num, err_vec,
        input  nClear, Enable_Odd, Enable_Even, Enable_Term, Enable_Error_Counter,
        input  busy, done, aborted, iter_cnt, err_iters
    );

    modport slave (
        input  start, stop, iter_num, err_vec,
        output nClear, Enable_Odd, Enable_Even, Enable_Term, Enable_Error_Counter,
        output busy, done, aborted, iter_cnt, err_iters
    );
endinterface

// File: rtl/fptd_iteration_controller.sv
// Iteration sequencer for a razor-protected fully-parallel decoder array: clear, termination flush,
// odd/even iterations with replay on razor errors. Define FPTD_RAZOR_STATS_EN to build the err_iters counter.
module fptd_iteration_controller #(
    parameter int FL        = 40,
    parameter int MAX_ITER  = 32,
    parameter int TERM_CYC  = 3,
    parameter int MAX_RETRY = 3
) (
    input logic                     Clock,
    input logic                     nReset,
    fptd_iteration_controller_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_ITER + 1);
    localparam int TC_W  = $clog2(TERM_CYC + 1);
    localparam int RT_W  = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] MAX_ITER_C  = CNT_W'(MAX_ITER);
    localparam logic [TC_W-1:0]  TERM_LAST   = TC_W'(TERM_CYC - 1);
    localparam logic [RT_W-1:0]  MAX_RETRY_C = RT_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_TERM, S_ODD, S_EVEN, S_EVAL, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [TC_W-1:0]  term_cnt_q, term_cnt_d;
    logic [RT_W-1:0]  retry_cnt_q, retry_cnt_d;
    logic [CNT_W-1:0] iter_tgt_q, iter_tgt_d;
    logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
    logic             iter_err_q, iter_err_d;
    logic             aborted_q, aborted_d;

    logic             err_any;
    logic             bad;
    logic             active;
    logic [CNT_W-1:0] iter_inc;

    assign err_any  = |bus.err_vec;
    assign bad      = iter_err_q | err_any;
    assign active   = state_q inside {S_CLEAR, S_TERM, S_ODD, S_EVEN, S_EVAL};
    assign iter_inc = iter_cnt_q + 1'b1;

    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d     = state_q;
        term_cnt_d  = term_cnt_q;
        retry_cnt_d = retry_cnt_q;
        iter_tgt_d  = iter_tgt_q;
        iter_cnt_d  = iter_cnt_q;
        iter_err_d  = iter_err_q;
        aborted_d   = aborted_q;

        if (active && bus.stop) begin
            aborted_d = 1'b1;
            state_d   = S_DONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.iter_num == '0)             iter_tgt_d = CNT_W'(1);
                        else if (bus.iter_num > MAX_ITER_C) iter_tgt_d = MAX_ITER_C;
                        else                                iter_tgt_d = bus.iter_num;
                        iter_cnt_d  = '0;
                        retry_cnt_d = '0;
                        aborted_d   = 1'b0;
                        state_d     = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    term_cnt_d = '0;
                    state_d    = S_TERM;
                end
                S_TERM: begin
                    if (term_cnt_q == TERM_LAST) state_d = S_ODD;
                    else                         term_cnt_d = term_cnt_q + 1'b1;
                end
                S_ODD: begin
                    iter_err_d = 1'b0;
                    state_d    = S_EVEN;
                end
                S_EVEN: begin
                    // The flag seen during EVEN belongs to the preceding ODD pulse.
                    iter_err_d = iter_err_q | err_any;
                    state_d    = S_EVAL;
                end
                S_EVAL: begin
                    if (bad) begin
                        if (retry_cnt_q < MAX_RETRY_C) begin
                            retry_cnt_d = retry_cnt_q + 1'b1;
                            state_d     = S_ODD;
                        end else begin
                            aborted_d = 1'b1;
                            state_d   = S_DONE;
                        end
                    end else begin
                        iter_cnt_d  = iter_inc;
                        retry_cnt_d = '0;
                        state_d     = (iter_inc == iter_tgt_q) ? S_DONE : S_ODD;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_IDLE;
            term_cnt_q  <= '0;
            retry_cnt_q <= '0;
            iter_tgt_q  <= '0;
            iter_cnt_q  <= '0;
            iter_err_q  <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            term_cnt_q  <= term_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            iter_tgt_q  <= iter_tgt_d;
            iter_cnt_q  <= iter_cnt_d;
            iter_err_q  <= iter_err_d;
            aborted_q   <= aborted_d;
        end
    end

    always_comb begin
        bus.nClear               = 1'b1;
        bus.Enable_Odd           = 1'b0;
        bus.Enable_Even          = 1'b0;
        bus.Enable_Term          = 1'b0;
        bus.Enable_Error_Counter = 1'b0;
        bus.busy                 = active;
        bus.done                 = 1'b0;
        case (state_q)
            S_CLEAR: bus.nClear      = 1'b0;
            S_TERM:  bus.Enable_Term = 1'b1;
            S_ODD:   bus.Enable_Odd  = 1'b1;
            S_EVEN:  bus.Enable_Even = 1'b1;
            S_DONE: begin
                bus.done                 = 1'b1;
                bus.Enable_Error_Counter = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.aborted  = aborted_q;
    assign bus.iter_cnt = iter_cnt_q;

`ifdef FPTD_RAZOR_STATS_EN
    logic        err_inc;
    logic [15:0] err_iters_q, err_iters_d;

    // A replay is counted exactly when EVAL sends the same iteration back to ODD.
    assign err_inc = (state_q == S_EVAL) && !bus.stop && bad && (retry_cnt_q < MAX_RETRY_C);

    always_comb begin
        err_iters_d = err_iters_q;
        if (err_inc && (err_iters_q != 16'hFFFF)) err_iters_d = err_iters_q + 16'd1;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) err_iters_q <= '0;
        else         err_iters_q <= err_iters_d;
    end

    assign bus.err_iters = err_iters_q;
`else
    assign bus.err_iters = '0;
`endif
endmodule

// File: tb/tb_fptd_iteration_controller.sv
// Scoreboard bench for fptd_iteration_controller: expected frame summaries are queued at stimulus
// time and compared when done pulses; enable exclusivity is monitored every cycle.
module tb_fptd_iteration_controller;
    localparam int FL        = 40;
    localparam int MAX_ITER  = 32;
    localparam int TERM_CYC  = 3;
    localparam int MAX_RETRY = 3;
    localparam int CNT_W     = $clog2(MAX_ITER + 1);
`ifdef FPTD_RAZOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic             timeout;
        logic [15:0]      lat;
        logic [7:0]       clr;
        logic [7:0]       term;
        logic [7:0]       odd;
        logic [7:0]       even;
        logic [CNT_W-1:0] iters;
        logic             abrt;
        logic [15:0]      errs;
        logic             busy1;
        logic             busy;
    } frame_t;

    logic Clock  = 1'b0;
    logic nReset = 1'b0;

    fptd_iteration_controller_if #(.FL(FL), .MAX_ITER(MAX_ITER)) bus ();

    fptd_iteration_controller #(
        .FL(FL), .MAX_ITER(MAX_ITER), .TERM_CYC(TERM_CYC), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .Clock (Clock),
        .nReset(nReset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int     checks = 0;
    int     errors = 0;
    int     exp_err_iters = 0;
    frame_t sb_q[$];
    frame_t obs;

    int mon_clr = 0, mon_term = 0, mon_odd = 0, mon_even = 0, mon_overlap = 0;

    always @(negedge Clock) begin
        int act;
        act = 0;
        if (!bus.nClear)     begin act++; mon_clr++;  end
        if (bus.Enable_Term) begin act++; mon_term++; end
        if (bus.Enable_Odd)  begin act++; mon_odd++;  end
        if (bus.Enable_Even) begin act++; mon_even++; end
        if (act > 1) mon_overlap++;
    end

    function automatic frame_t make_exp(input int lat, input int term, input int att,
                                        input int iters, input bit abrt);
        frame_t f;
        f         = '0;
        f.lat     = 16'(lat);
        f.clr     = 8'd1;
        f.term    = 8'(term);
        f.odd     = 8'(att);
        f.even    = 8'(att);
        f.iters   = CNT_W'(iters);
        f.abrt    = abrt;
        f.errs    = STATS ? 16'(exp_err_iters) : 16'd0;
        f.busy1   = 1'b1;
        f.busy    = 1'b0;
        f.timeout = 1'b0;
        return f;
    endfunction

    function automatic string fmt(input frame_t f);
        return $sformatf("timeout=%0d lat=%0d clr=%0d term=%0d odd=%0d even=%0d iters=%0d aborted=%0d errs=%0d busy_c1=%0d busy_done=%0d",
                         f.timeout, f.lat, f.clr, f.term, f.odd, f.even, f.iters, f.abrt, f.errs, f.busy1, f.busy);
    endfunction

    // Runs one frame: start in cycle 0, err_pat on err_vec in cycles err_from..err_to,
    // stop in cycle stop_at, optional start pulses in cycles 2..3. Fills obs on done.
    task automatic run_frame(input logic [CNT_W-1:0] n, input int err_from, input int err_to,
                             input logic [FL-1:0] err_pat, input int stop_at,
                             input bit start_while_busy, input int budget);
        int b_clr, b_term, b_odd, b_even;
        @(posedge Clock); #1;
        b_clr = mon_clr; b_term = mon_term; b_odd = mon_odd; b_even = mon_even;
        obs          = '0;
        obs.timeout  = 1'b1;
        bus.iter_num = n;
        bus.start    = 1'b1;
        bus.stop     = 1'b0;
        bus.err_vec  = '0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge Clock); #1;
            bus.start   = start_while_busy && (c == 2 || c == 3);
            bus.err_vec = (c >= err_from && c <= err_to) ? err_pat : '0;
            bus.stop    = (c == stop_at);
            @(negedge Clock);
            if (c == 1) obs.busy1 = bus.busy;
            if (bus.done) begin
                obs.timeout = 1'b0;
                obs.lat     = 16'(c);
                obs.iters   = bus.iter_cnt;
                obs.abrt    = bus.aborted;
                obs.errs    = bus.err_iters;
                obs.busy    = bus.busy;
                break;
            end
        end
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.err_vec = '0;
        #1;
        obs.clr  = 8'(mon_clr - b_clr);
        obs.term = 8'(mon_term - b_term);
        obs.odd  = 8'(mon_odd - b_odd);
        obs.even = 8'(mon_even - b_even);
    endtask

    task automatic test_reset();
        logic [29:0] got;
        bus.start = 1'b0; bus.stop = 1'b0; bus.iter_num = '0; bus.err_vec = '0;
        nReset = 1'b0;
        repeat (2) @(negedge Clock);
        got = {bus.nClear, bus.Enable_Odd, bus.Enable_Even, bus.Enable_Term, bus.Enable_Error_Counter,
               bus.busy, bus.done, bus.aborted, bus.iter_cnt, bus.err_iters};
        checks++;
        if (got !== {1'b1, 29'd0}) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", got, {1'b1, 29'd0});
        end
        @(posedge Clock); #1 nReset = 1'b1;
        repeat (2) @(negedge Clock);
        got = {bus.nClear, bus.Enable_Odd, bus.Enable_Even, bus.Enable_Term, bus.Enable_Error_Counter,
               bus.busy, bus.done, bus.aborted, bus.iter_cnt, bus.err_iters};
        checks++;
        if (got !== {1'b1, 29'd0}) begin
            errors++; $display("FAIL idle_after_reset got %h exp %h", got, {1'b1, 29'd0});
        end
    endtask

    task automatic test_basic();
        frame_t      e;
        logic [8:0]  post;
        sb_q.push_back(make_exp(2 + TERM_CYC + 3 * 4, TERM_CYC, 4, 4, 1'b0));
        run_frame(CNT_W'(4), 0, -1, '0, -1, 1'b0, 60);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL basic_frame got %s exp %s", fmt(obs), fmt(e)); end
        @(negedge Clock);
        post = {bus.done, bus.busy, bus.aborted, bus.iter_cnt};
        checks++;
        if (post !== {3'b000, CNT_W'(4)}) begin
            errors++; $display("FAIL basic_after_done got %h exp %h", post, {3'b000, CNT_W'(4)});
        end
    endtask

    task automatic test_razor_replay();
        frame_t e;
        exp_err_iters += 1;
        sb_q.push_back(make_exp(2 + TERM_CYC + 3 * 3, TERM_CYC, 3, 2, 1'b0));
        // Cycle 6 is the EVEN pulse of the first iteration.
        run_frame(CNT_W'(2), 6, 6, FL'(40'h20), -1, 1'b0, 60);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL replay_frame got %s exp %s", fmt(obs), fmt(e)); end
    endtask

    task automatic test_razor_abort();
        frame_t e;
        exp_err_iters += MAX_RETRY;
        sb_q.push_back(make_exp(2 + TERM_CYC + 3 * (MAX_RETRY + 1), TERM_CYC, MAX_RETRY + 1, 0, 1'b1));
        run_frame(CNT_W'(3), 1, 1000, '1, -1, 1'b0, 60);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL abort_frame got %s exp %s", fmt(obs), fmt(e)); end
        @(negedge Clock);
        checks++;
        if (bus.aborted !== 1'b1) begin
            errors++; $display("FAIL abort_held got %b exp 1", bus.aborted);
        end
    endtask

    task automatic test_stop();
        frame_t e;
        logic   busy_seen;
        sb_q.push_back(make_exp(4, 2, 0, 0, 1'b1));
        run_frame(CNT_W'(5), 0, -1, '0, 3, 1'b1, 60);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stop_frame got %s exp %s", fmt(obs), fmt(e)); end
        busy_seen = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            busy_seen = busy_seen | bus.busy | bus.done;
        end
        checks++;
        if (busy_seen !== 1'b0) begin
            errors++; $display("FAIL stop_start_ignored got busy/done %b exp 0", busy_seen);
        end
    endtask

    task automatic test_reset_mid_frame();
        frame_t      e;
        logic [29:0] got;
        @(posedge Clock); #1;
        bus.iter_num = CNT_W'(2);
        bus.start    = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge Clock); #1;
            bus.start = 1'b0;
            @(negedge Clock);
        end
        checks++;
        if (bus.Enable_Even !== 1'b1) begin
            errors++; $display("FAIL reset_setup_even got %b exp 1", bus.Enable_Even);
        end
        #2 nReset = 1'b0;
        #1;
        exp_err_iters = 0;
        got = {bus.nClear, bus.Enable_Odd, bus.Enable_Even, bus.Enable_Term, bus.Enable_Error_Counter,
               bus.busy, bus.done, bus.aborted, bus.iter_cnt, bus.err_iters};
        checks++;
        if (got !== {1'b1, 29'd0}) begin
            errors++; $display("FAIL async_reset_outputs got %h exp %h", got, {1'b1, 29'd0});
        end
        @(posedge Clock); #1 nReset = 1'b1;
        sb_q.push_back(make_exp(2 + TERM_CYC + 3 * 3, TERM_CYC, 3, 3, 1'b0));
        run_frame(CNT_W'(3), 0, -1, '0, -1, 1'b0, 60);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL post_reset_frame got %s exp %s", fmt(obs), fmt(e)); end
    endtask

    task automatic test_iter_bounds();
        frame_t e;
        sb_q.push_back(make_exp(2 + TERM_CYC + 3, TERM_CYC, 1, 1, 1'b0));
        run_frame(CNT_W'(0), 0, -1, '0, -1, 1'b0, 60);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL iter_zero_frame got %s exp %s", fmt(obs), fmt(e)); end
        sb_q.push_back(make_exp(2 + TERM_CYC + 3 * MAX_ITER, TERM_CYC, MAX_ITER, MAX_ITER, 1'b0));
        run_frame(CNT_W'(MAX_ITER + 5), 0, -1, '0, -1, 1'b0, 200);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL iter_sat_frame got %s exp %s", fmt(obs), fmt(e)); end
    endtask

    task automatic test_exclusivity();
        checks++;
        if (mon_overlap !== 0) begin
            errors++; $display("FAIL enable_exclusive got %0d overlapping cycles exp 0", mon_overlap);
        end
        checks++;
        if (sb_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drained got %0d entries exp 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_razor_replay();
        test_razor_abort();
        test_stop();
        test_reset_mid_frame();
        test_iter_bounds();
        test_exclusivity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule
